// File: rtl/nway_cache.sv
// N-way set-associative write-back/write-allocate cache with tree pseudo-LRU replacement.
// Hit, write-back and fill control share one FSM; requests are held by the CPU until mem_resp.
module nway_cache #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       mem_address,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [1:0]              mem_byte_enable,
  input  logic [15:0]             mem_wdata,
  output logic [15:0]             mem_rdata,
  output logic                    mem_resp,
  output logic [ADDR_W-1:0]       pmem_address,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [8*LINE_BYTES-1:0] pmem_wdata,
  input  logic [8*LINE_BYTES-1:0] pmem_rdata,
  input  logic                    pmem_resp
);
  localparam int unsigned OFF = $clog2(LINE_BYTES);
  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TAG = ADDR_W - IDX - OFF;
  localparam int unsigned LW  = 8 * LINE_BYTES;
  localparam int unsigned LV  = $clog2(WAYS);
  localparam int unsigned WW  = OFF - 1;

  typedef enum logic [1:0] {StIdle, StResp, StWb, StFill} state_e;

  logic [LW-1:0]   r_data  [SETS][WAYS];
  logic [TAG-1:0]  r_tag   [SETS][WAYS];
  logic [WAYS-1:0] r_valid [SETS];
  logic [WAYS-1:0] r_dirty [SETS];
  logic [WAYS-2:0] r_plru  [SETS];
  logic [15:0]     r_rdata;
  logic [LV-1:0]   r_victim;
  state_e          r_state;
  state_e          w_state_next;

  logic [TAG-1:0]  w_tag;
  logic [IDX-1:0]  w_idx;
  logic [WW-1:0]   w_word;
  logic            w_req, w_hit, w_has_inv, w_hit_now, w_wb_done, w_fill_done;
  logic [WAYS-1:0] w_hit_vec;
  logic [LV-1:0]   w_hit_way, w_inv_way, w_miss_victim;
  logic [LW-1:0]   w_line;
  int unsigned     w_base;
  logic            w_unused_addr0;

  // Tree nodes are heap-ordered: node n has children 2n+1 (lower) and 2n+2 (upper).
  function automatic logic [LV-1:0] f_victim(input logic [WAYS-2:0] t);
    int unsigned   n;
    logic [LV-1:0] v;
    n = 0;
    v = '0;
    for (int l = 0; l < int'(LV); l++) begin
      v[LV-1-l] = t[n];
      n = t[n] ? 2 * n + 2 : 2 * n + 1;
    end
    return v;
  endfunction

  function automatic logic [WAYS-2:0] f_touch(input logic [WAYS-2:0] t, input logic [LV-1:0] w);
    int unsigned n;
    logic        b;
    n = 0;
    for (int l = 0; l < int'(LV); l++) begin
      b    = w[LV-1-l];
      t[n] = ~b;
      n    = b ? 2 * n + 2 : 2 * n + 1;
    end
    return t;
  endfunction

  assign w_tag          = mem_address[ADDR_W-1 -: TAG];
  assign w_idx          = mem_address[OFF +: IDX];
  assign w_word         = mem_address[1 +: WW];
  assign w_unused_addr0 = mem_address[0];
  assign w_req          = mem_read | mem_write;
  assign w_hit_now      = (r_state == StIdle) && w_req && w_hit;
  assign w_wb_done      = (r_state == StWb) && pmem_resp;
  assign w_fill_done    = (r_state == StFill) && pmem_resp;

  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    w_inv_way = '0;
    w_has_inv = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
      if (w_hit_vec[w]) w_hit_way = LV'(w);
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = LV'(w);
      end
    end
    w_hit         = |w_hit_vec;
    w_miss_victim = w_has_inv ? w_inv_way : f_victim(r_plru[w_idx]);
    w_line        = r_data[w_idx][w_hit_way];
    w_base        = 32'(w_word) * 16;
  end

  always_comb begin
    w_state_next = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {w_tag, w_idx, {OFF{1'b0}}};
    unique case (r_state)
      StIdle: begin
        if (w_req) begin
          if (w_hit) begin
            w_state_next = StResp;
          end else if (r_valid[w_idx][w_miss_victim] && r_dirty[w_idx][w_miss_victim]) begin
            w_state_next = StWb;
          end else begin
            w_state_next = StFill;
          end
        end
      end
      StResp: begin
        mem_resp     = 1'b1;
        w_state_next = StIdle;
      end
      StWb: begin
        pmem_write   = 1'b1;
        pmem_address = {r_tag[w_idx][r_victim], w_idx, {OFF{1'b0}}};
        if (pmem_resp) w_state_next = StFill;
      end
      StFill: begin
        pmem_read = 1'b1;
        if (pmem_resp) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign pmem_wdata = r_data[w_idx][r_victim];
  assign mem_rdata  = r_rdata;

  // Data, tags and the read register are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_hit_now) begin
      if (mem_write) begin
        if (mem_byte_enable[0]) r_data[w_idx][w_hit_way][w_base +: 8] <= mem_wdata[7:0];
        if (mem_byte_enable[1]) r_data[w_idx][w_hit_way][w_base + 8 +: 8] <= mem_wdata[15:8];
      end else begin
        r_rdata <= w_line[w_base +: 16];
      end
    end
    if (w_fill_done) begin
      r_data[w_idx][r_victim] <= pmem_rdata;
      r_tag[w_idx][r_victim]  <= w_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_victim <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      r_state <= w_state_next;
      if ((r_state == StIdle) && w_req && !w_hit) r_victim <= w_miss_victim;
      if (w_hit_now) begin
        r_plru[w_idx] <= f_touch(r_plru[w_idx], w_hit_way);
        if (mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      if (w_wb_done) r_dirty[w_idx][r_victim] <= 1'b0;
      if (w_fill_done) begin
        r_valid[w_idx][r_victim] <= 1'b1;
        r_dirty[w_idx][r_victim] <= 1'b0;
        r_plru[w_idx]            <= f_touch(r_plru[w_idx], r_victim);
      end
    end
  end

endmodule

// File: tb/tb_nway_cache.sv
// Scoreboard bench for nway_cache: expected CPU read data and expected pmem transactions are
// queued at stimulus time and checked when the DUT responds.
module tb_nway_cache;
  logic         clk;
  logic         rst_n;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  typedef struct {bit rd; logic [15:0] d;} rexp_t;
  typedef struct {bit wr; logic [15:0] a; bit cw; int wi; logic [15:0] wv;} pexp_t;

  rexp_t        q_r[$];
  pexp_t        q_p[$];
  int           n_total;
  int           n_bad;
  logic [127:0] mem [0:4095];
  bit           mem_init_done;
  int           pm_cnt;

  nway_cache dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int l, input int k);
    return 16'(l * 8 + k) ^ 16'hA000;
  endfunction

  function automatic logic [127:0] init_line(input int l);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = init_word(l, k);
    if (l == 4) v[15:0] = 16'h1234;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Physical memory: responds 3 cycles after a strobe is seen.
  assign pmem_rdata = mem[pmem_address[15:4]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_cnt    <= 0;
      pmem_resp <= 1'b0;
      if (!mem_init_done) begin
        for (int i = 0; i < 4096; i++) mem[i] <= init_line(i);
        mem_init_done <= 1'b1;
      end
    end else begin
      pmem_resp <= 1'b0;
      if ((pmem_read || pmem_write) && !pmem_resp) begin
        if (pm_cnt == 2) begin
          pm_cnt    <= 0;
          pmem_resp <= 1'b1;
          if (pmem_write) mem[pmem_address[15:4]] <= pmem_wdata;
        end else begin
          pm_cnt <= pm_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && mem_resp) begin
      rexp_t e;
      if (q_r.size() == 0) begin
        chk("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e = q_r.pop_front();
        if (e.rd) chk("rdata", {16'd0, mem_rdata}, {16'd0, e.d});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && pmem_resp && (pmem_read || pmem_write)) begin
      pexp_t e;
      if (q_p.size() == 0) begin
        chk("pmem_unexpected", {16'd0, pmem_address}, 32'hFFFF_FFFF);
      end else begin
        e = q_p.pop_front();
        chk("pmem_kind", {31'd0, pmem_write}, {31'd0, e.wr});
        chk("pmem_addr", {16'd0, pmem_address}, {16'd0, e.a});
        if (e.cw) chk("wb_word", {16'd0, pmem_wdata[e.wi*16 +: 16]}, {16'd0, e.wv});
      end
    end
  end

  task automatic push_pm(input bit wr, input logic [15:0] a, input bit cw, input int wi,
                         input logic [15:0] wv);
    pexp_t e;
    e.wr = wr;
    e.a  = a;
    e.cw = cw;
    e.wi = wi;
    e.wv = wv;
    q_p.push_back(e);
  endtask

  task automatic access(input logic [15:0] a, input bit rd, input bit wr, input logic [1:0] be,
                        input logic [15:0] wd, input logic [15:0] exp, input bit miss);
    int    n;
    int    pm;
    rexp_t e;
    @(negedge clk);
    mem_address     = a;
    mem_read        = rd;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    e.rd = rd && !wr;
    e.d  = exp;
    q_r.push_back(e);
    n  = 0;
    pm = 0;
    do begin
      @(negedge clk);
      n++;
      if (pmem_read || pmem_write) pm++;
    end while (!mem_resp && n < 100);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!mem_resp) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    if (miss) begin
      chk("miss_pmem_seen", {31'd0, pm > 0}, 32'd1);
    end else begin
      chk("hit_latency", n, 32'd1);
      chk("hit_no_pmem", pm, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] old;
    int          n;
    n_total         = 0;
    n_bad           = 0;
    rst_n           = 1'b0;
    mem_address     = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_wdata       = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
    chk("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    rst_n = 1'b1;

    // Cold miss then fill.
    push_pm(1'b0, 16'h0040, 1'b0, 0, 16'h0);
    access(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0, 16'h1234, 1'b1);

    // Full-word write hit, readback.
    access(16'h0042, 1'b0, 1'b1, 2'b11, 16'hBEEF, 16'h0, 1'b0);
    access(16'h0042, 1'b1, 1'b0, 2'b00, 16'h0, 16'hBEEF, 1'b0);

    // Low-byte-only write.
    old = init_word(4, 2);
    access(16'h0044, 1'b0, 1'b1, 2'b01, 16'hAA55, 16'h0, 1'b0);
    access(16'h0044, 1'b1, 1'b0, 2'b00, 16'h0, {old[15:8], 8'h55}, 1'b0);

    // Fill remaining ways of set 4, then evict dirty way0.
    push_pm(1'b0, 16'h00C0, 1'b0, 0, 16'h0);
    access(16'h00C0, 1'b1, 1'b0, 2'b00, 16'h0, init_word(12, 0), 1'b1);
    push_pm(1'b0, 16'h0140, 1'b0, 0, 16'h0);
    access(16'h0140, 1'b1, 1'b0, 2'b00, 16'h0, init_word(20, 0), 1'b1);
    push_pm(1'b0, 16'h01C0, 1'b0, 0, 16'h0);
    access(16'h01C0, 1'b1, 1'b0, 2'b00, 16'h0, init_word(28, 0), 1'b1);
    push_pm(1'b1, 16'h0040, 1'b1, 1, 16'hBEEF);
    push_pm(1'b0, 16'h0240, 1'b0, 0, 16'h0);
    access(16'h0240, 1'b1, 1'b0, 2'b00, 16'h0, init_word(36, 0), 1'b1);
    access(16'h00C0, 1'b1, 1'b0, 2'b00, 16'h0, init_word(12, 0), 1'b0);
    chk("wb_mem_word2", {16'd0, mem[4][47:32]}, {16'd0, old[15:8], 8'h55});

    // Reset while a fill is outstanding.
    @(negedge clk);
    mem_address = 16'h0040;
    mem_read    = 1'b1;
    n = 0;
    while (!pmem_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fill_started", {31'd0, pmem_read}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("async_mem_resp", {31'd0, mem_resp}, 32'd0);
    mem_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_pm(1'b0, 16'h0040, 1'b0, 0, 16'h0);
    access(16'h0040, 1'b1, 1'b0, 2'b00, 16'h0, 16'h1234, 1'b1);

    // Read and write together count as a write.
    access(16'h0046, 1'b1, 1'b1, 2'b11, 16'h0F0F, 16'h0, 1'b0);
    access(16'h0046, 1'b1, 1'b0, 2'b00, 16'h0, 16'h0F0F, 1'b0);

    repeat (3) @(negedge clk);
    chk("rdata_queue_empty", q_r.size(), 32'd0);
    chk("pmem_queue_empty", q_p.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/nway_cache.md
Name: nway_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache between the LC-3b CPU memory port and physical memory.
- Successor to the fixed 2-way datapath: the way count, set count and line size are now parameters.
- Replacement is tree pseudo-LRU instead of a single LRU bit.
- Datapath and control FSM (hit, write-back, fill) live in one block.

Parameters:
WAYS, 4, associativity; power of 2, >=2
SETS, 8, sets; power of 2
LINE_BYTES, 16, bytes per line; power of 2, >=4
ADDR_W, 16, address width; derived OFF=log2(LINE_BYTES), IDX=log2(SETS), TAG=ADDR_W-IDX-OFF

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_address  in  ADDR_W  CPU byte address
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_byte_enable  in  2  byte lanes of write word
mem_wdata  in  16  write word
mem_rdata  out  16  read word, valid while mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_address  out  ADDR_W  line-aligned physical address (low OFF bits 0)
pmem_read  out  1  line fill request
pmem_write  out  1  line write-back request
pmem_wdata  out  8*LINE_BYTES  victim line
pmem_rdata  in  8*LINE_BYTES  fill line
pmem_resp  in  1  pmem completion

Behaviour:
- Address split: tag=addr[ADDR_W-1:IDX+OFF], index=addr[IDX+OFF-1:OFF], word=addr[OFF-1:1]; addr[0] ignored.
- Per set and way: data, tag, valid, dirty. Per set: WAYS-1 PLRU bits.
- Reset (async, rst_n=0): all valid, dirty and PLRU bits cleared; state IDLE; mem_resp, pmem_read, pmem_write = 0. Data and tag arrays are not reset. Any in-flight fill or write-back is abandoned and the pmem strobes drop immediately.
- FSM states: IDLE, RESP, WB, FILL.
- IDLE, no request: stay.
- IDLE, request, hit (valid and tag equal in exactly one way):
  - read: capture the word into the mem_rdata register.
  - write: merge mem_wdata into the word per mem_byte_enable and set dirty.
  - Update PLRU; go to RESP.
- IDLE, request, miss: choose victim = lowest-index invalid way, else PLRU victim. Go to WB if victim valid and dirty, else FILL.
- RESP: mem_resp=1 for exactly one cycle, then IDLE. Hit latency is request to mem_resp in 1 cycle.
- WB:
  - pmem_write=1; pmem_address={victim tag, index, 0}; pmem_wdata = victim line; all held stable.
  - On pmem_resp: clear victim dirty, go to FILL.
- FILL:
  - pmem_read=1; pmem_address={req tag, index, 0}.
  - On pmem_resp: write pmem_rdata, tag, valid=1, dirty=0 into victim way, then IDLE. The re-check there hits.
- PLRU: binary tree, node bit 0 = victim in lower half. On hit or fill of way w, each node on w's path is set to point away from w. Victim is found by following the bits from the root.
- mem_read and mem_write both high: treated as a write.
- Requester must drop the request in the cycle after mem_resp. A request still high in IDLE is a new access.
- pmem_resp outside WB/FILL is ignored.
- Only one way may match a tag; no multi-hit handling required.

Test Plan:
1. Reset, read 0x0040 -> miss, no write-back. pmem_read=1 with pmem_address=0x0040. Return a line whose word0=0x1234. mem_resp pulses 1 cycle after re-check with mem_rdata=0x1234.
2. Write 0x0042, wdata=0xBEEF, be=2'b11 -> hit, mem_resp 1 cycle later, no pmem activity. Read 0x0042 -> 0xBEEF.
3. Write 0x0044, wdata=0xAA55, be=2'b01 -> byte 0x55 merged, upper byte unchanged. Read 0x0044 -> {old[15:8],0x55}.
4. Fill set 4 in order 0x0040, 0x00C0, 0x0140, 0x01C0 (way0 dirty from test 2), then read 0x0240:
   - victim way0; pmem_write at 0x0040 carrying 0xBEEF in word1;
   - then pmem_read at 0x0240;
   - a later read of 0x00C0 still hits.
5. Assert rst_n=0 mid-FILL -> pmem_read falls without waiting for a clock. After release, read 0x0040 misses again.
6. Assert mem_read and mem_write together at 0x0046, wdata=0x0F0F -> write performed. Read returns 0x0F0F.
